// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the EX stage and muldiv_unit.
//   master : EX-stage side, drives i_start/i_funct/i_op_a/i_op_b/i_flush and
//            observes o_busy/o_done/o_div_by_zero/o_hi/o_lo.
//   slave  : muldiv_unit side, the reverse directions.
interface muldiv_unit_if #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
);
    logic                           i_start;
    logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct;
    logic [DATA_BUS_WIDTH-1:0]      i_op_a;
    logic [DATA_BUS_WIDTH-1:0]      i_op_b;
    logic                           i_flush;
    logic                           o_busy;
    logic                           o_done;
    logic                           o_div_by_zero;
    logic [DATA_BUS_WIDTH-1:0]      o_hi;
    logic [DATA_BUS_WIDTH-1:0]      o_lo;

    modport master (
        output i_start, i_funct, i_op_a, i_op_b, i_flush,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_funct, i_op_a, i_op_b, i_flush,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   i_clk   : clock, all state changes on the rising edge
//   i_reset : synchronous active-high reset (returns to IDLE, clears HI/LO)
//   bus     : muldiv_unit_if.slave
//             i_start/i_funct/i_op_a/i_op_b request, i_flush abort,
//             o_busy (RUN/FIX), o_done pulse, o_div_by_zero, o_hi/o_lo.
// Optional macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle
// combinational product and go straight to FIX; divide is unaffected.
module muldiv_unit #(
    parameter int DATA_BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
) (
    input logic           i_clk,
    input logic           i_reset,
    muldiv_unit_if.slave  bus
);
    localparam int W     = DATA_BUS_WIDTH;
    localparam int CNT_W = $clog2(W);

    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FUNCT_MULT  = ALU_FUNCT_BUS_WIDTH'(8'h18);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FUNCT_MULTU = ALU_FUNCT_BUS_WIDTH'(8'h19);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FUNCT_DIV   = ALU_FUNCT_BUS_WIDTH'(8'h1A);
    localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] FUNCT_DIVU  = ALU_FUNCT_BUS_WIDTH'(8'h1B);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [2*W-1:0]   acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]     opnd;     // |multiplicand| or |divisor|
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;
    logic [W-1:0]     hi_q, lo_q;
    logic             busy_q, done_q, dbz_q;

    logic             funct_ok, is_div, is_sgn, can_accept;
    logic             a_neg, b_neg;
    logic [W-1:0]     a_abs, b_abs;
    logic [W:0]       mul_sum, div_trial;
    logic [2*W-1:0]   mul_next, div_next, acc_neg;
    logic [W-1:0]     fix_hi, fix_lo;

    always_comb begin
        funct_ok = 1'b0;
        is_div   = 1'b0;
        is_sgn   = 1'b0;
        case (bus.i_funct)
            FUNCT_MULT:  begin funct_ok = 1'b1; is_sgn = 1'b1; end
            FUNCT_MULTU: begin funct_ok = 1'b1; end
            FUNCT_DIV:   begin funct_ok = 1'b1; is_div = 1'b1; is_sgn = 1'b1; end
            FUNCT_DIVU:  begin funct_ok = 1'b1; is_div = 1'b1; end
            default:     ;
        endcase
        // flush overrides a simultaneous request in every state
        can_accept = bus.i_start && !bus.i_flush && funct_ok &&
                     (state == S_IDLE || state == S_DONE);
        a_neg = is_sgn & bus.i_op_a[W-1];
        b_neg = is_sgn & bus.i_op_b[W-1];
        a_abs = a_neg ? (~bus.i_op_a + 1'b1) : bus.i_op_a;
        b_abs = b_neg ? (~bus.i_op_b + 1'b1) : bus.i_op_b;
    end

    // Shift-add step: add multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole register right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[W-1:1]};
    end

    // Restoring step: shift next dividend bit into the remainder and
    // subtract; keep the difference only if it did not go negative.
    always_comb begin
        div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
        div_next  = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc[W-2:0], 1'b1};
    end

    always_comb begin
        acc_neg = ~acc + 1'b1;
        if (op_div) begin
            fix_lo = neg_res ? acc_neg[W-1:0] : acc[W-1:0];
            fix_hi = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        end else begin
            fix_hi = neg_res ? acc_neg[2*W-1:W] : acc[2*W-1:W];
            fix_lo = neg_res ? acc_neg[W-1:0]   : acc[W-1:0];
        end
    end

`ifdef MULDIV_FAST_MULT_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    // Sign/zero-extend to 2W so one truncated product serves both MULT and MULTU.
    always_comb begin
        fast_a    = {{W{is_sgn & bus.i_op_a[W-1]}}, bus.i_op_a};
        fast_b    = {{W{is_sgn & bus.i_op_b[W-1]}}, bus.i_op_b};
        fast_prod = fast_a * fast_b;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (can_accept) begin
                        op_div  <= is_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= CNT_W'(W - 1);
                        if (is_div && bus.i_op_b == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                        end
`ifdef MULDIV_FAST_MULT_EN
                        else if (!is_div) begin
                            acc     <= fast_prod;
                            neg_res <= 1'b0;
                            state   <= S_FIX;
                            busy_q  <= 1'b1;
                        end
`endif
                        else begin
                            acc    <= is_div ? {{W{1'b0}}, a_abs} : {{W{1'b0}}, b_abs};
                            opnd   <= is_div ? b_abs : a_abs;
                            state  <= S_RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.i_flush) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc <= op_div ? div_next : mul_next;
                        if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (bus.i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
module tb_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

`ifdef MULDIV_FAST_MULT_EN
    localparam int         MUL_DONE  = 2;
    localparam int         MUL_BUSY  = 1;
    localparam logic [5:0] ABORT_FN  = F_DIV;
`else
    localparam int         MUL_DONE  = 34;
    localparam int         MUL_BUSY  = 33;
    localparam logic [5:0] ABORT_FN  = F_MULT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if #(.DATA_BUS_WIDTH(32), .ALU_FUNCT_BUS_WIDTH(6)) bus ();

    muldiv_unit #(.DATA_BUS_WIDTH(32), .ALU_FUNCT_BUS_WIDTH(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the next posedge is the accepting edge E0.
    // Returns at the negedge of the o_done cycle (or after max_cyc cycles).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int busy_cyc, output logic dbz);
        bus.i_start = 1'b1;
        bus.i_funct = f;
        bus.i_op_a  = a;
        bus.i_op_b  = b;
        @(negedge clk);
        bus.i_start = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        dbz      = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.o_busy) busy_cyc++;
            if (bus.o_done) begin
                done_cyc = c;
                dbz      = bus.o_div_by_zero;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic watch(input int n, output int dones, output int busies);
        dones  = 0;
        busies = 0;
        for (int c = 0; c < n; c++) begin
            if (bus.o_done) dones++;
            if (bus.o_busy) busies++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc, bc, nd, nb;
        logic dz;

        bus.i_start = 1'b0;
        bus.i_funct = '0;
        bus.i_op_a  = '0;
        bus.i_op_b  = '0;
        bus.i_flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_hi",   bus.o_hi, 0);
        check("rst_lo",   bus.o_lo, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_dbz",  bus.o_div_by_zero, 0);

        @(negedge clk);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc, dz);
        check("mult_done_cyc", dc, MUL_DONE);
        check("mult_busy_cyc", bc, MUL_BUSY);
        check("mult_hi", bus.o_hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.o_lo, 32'hFFFF_FFEB);

        @(negedge clk);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, dz);
        check("multu_done_cyc", dc, MUL_DONE);
        check("multu_busy_cyc", bc, MUL_BUSY);
        check("multu_hi", bus.o_hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.o_lo, 32'h0000_0001);

        @(negedge clk);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, dc, bc, dz);
        check("div_done_cyc", dc, 34);
        check("div_busy_cyc", bc, 33);
        check("div_lo", bus.o_lo, 32'hFFFF_FFFD);
        check("div_hi", bus.o_hi, 32'hFFFF_FFFF);

        @(negedge clk);
        run_op(F_DIVU, 32'd100, 32'd7, dc, bc, dz);
        check("divu_done_cyc", dc, 34);
        check("divu_lo", bus.o_lo, 32'd14);
        check("divu_hi", bus.o_hi, 32'd2);

        @(negedge clk);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc, dz);
        check("divwrap_lo", bus.o_lo, 32'h8000_0000);
        check("divwrap_hi", bus.o_hi, 32'h0000_0000);

        // 0x2211 / 0x100 leaves HI=0x11, LO=0x22 for the following tests
        @(negedge clk);
        run_op(F_DIVU, 32'h0000_2211, 32'h0000_0100, dc, bc, dz);
        check("preset_lo", bus.o_lo, 32'h22);
        check("preset_hi", bus.o_hi, 32'h11);

        @(negedge clk);
        run_op(F_DIVU, 32'd100, 32'd0, dc, bc, dz);
        check("dbz_done_cyc", dc, 1);
        check("dbz_flag", dz, 1);
        check("dbz_busy_cyc", bc, 0);
        check("dbz_hi", bus.o_hi, 32'h11);
        check("dbz_lo", bus.o_lo, 32'h22);

        // Unsupported funct is ignored
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_funct = F_ADD;
        bus.i_op_a  = 32'd5;
        bus.i_op_b  = 32'd6;
        @(negedge clk);
        bus.i_start = 1'b0;
        watch(40, nd, nb);
        check("add_busy", nb, 0);
        check("add_done", nd, 0);

        // Simultaneous start and flush: request dropped
        bus.i_start = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_funct = F_DIVU;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        watch(40, nd, nb);
        check("startflush_busy", nb, 0);
        check("startflush_done", nd, 0);

        // Flush in cycle 10
        bus.i_start = 1'b1;
        bus.i_funct = ABORT_FN;
        bus.i_op_a  = 32'hFFFF_FFFD;
        bus.i_op_b  = 32'd7;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_c10", bus.o_busy, 1);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_busy_c11", bus.o_busy, 0);
        watch(40, nd, nb);
        check("flush_done", nd, 0);
        check("flush_hi", bus.o_hi, 32'h11);
        check("flush_lo", bus.o_lo, 32'h22);

        // Reset in cycle 10
        bus.i_start = 1'b1;
        bus.i_funct = ABORT_FN;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", bus.o_busy, 0);
        check("rstmid_hi", bus.o_hi, 0);
        check("rstmid_lo", bus.o_lo, 0);
        watch(40, nd, nb);
        check("rstmid_done", nd, 0);

        // Back-to-back: second request accepted while in DONE
        run_op(F_MULTU, 32'd3, 32'd5, dc, bc, dz);
        check("b2b1_done_cyc", dc, MUL_DONE);
        check("b2b1_lo", bus.o_lo, 32'd15);
        check("b2b1_hi", bus.o_hi, 32'd0);
        run_op(F_DIVU, 32'd100, 32'd7, dc, bc, dz);
        check("b2b2_done_cyc", dc, 34);
        check("b2b2_busy_cyc", bc, 33);
        check("b2b2_lo", bus.o_lo, 32'd14);
        check("b2b2_hi", bus.o_hi, 32'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
